// File: rtl/prog_loader.sv
// UART boot loader: receives an A5/LEN/data/CHK frame over 8N1 serial, writes the
// payload into instruction memory and releases the CPU once the checksum matches.
module prog_loader #(
  parameter int CLKS_PER_BIT = 8,
  parameter int MEM_DEPTH    = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       prog_we,
  output logic [4:0] prog_addr,
  output logic [7:0] prog_data,
  output logic       cpu_run,
  output logic       busy,
  output logic       err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0]       MAX_LEN   = 8'(MEM_DEPTH);
  localparam logic [7:0]       SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_state_t;

  typedef enum logic [2:0] {
    F_SYNC,
    F_LEN,
    F_DATA,
    F_CHK,
    F_DONE
  } frame_state_t;

  // Handshake: the UART side offers r_byte_valid for exactly one clk with r_shift
  // stable alongside it; the frame side has no ready and must consume it that cycle.

  logic r_rx_meta;
  logic r_rx_sync;
  logic w_rx;

  uart_state_t      r_ustate;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_valid;
  logic             r_frame_err;

  frame_state_t r_fstate;
  logic [7:0]   r_len;
  logic [7:0]   r_sum;
  logic [4:0]   r_cnt;
  logic         r_prog_we;
  logic [4:0]   r_prog_addr;
  logic [7:0]   r_prog_data;
  logic         r_cpu_run;
  logic         r_busy;
  logic         r_err;

  // Synchronizer flops reset to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_rx = r_rx_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ustate     <= U_IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_ustate)
        U_IDLE: begin
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
          if (!w_rx) r_ustate <= U_START;
        end
        U_START: begin
          // Mid-start re-check: a low pulse shorter than half a bit is discarded.
          if (r_clk_cnt == HALF_M1) begin
            r_clk_cnt <= '0;
            r_ustate  <= w_rx ? U_IDLE : U_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        U_DATA: begin
          if (r_clk_cnt == FULL_M1) begin
            r_clk_cnt <= '0;
            r_shift   <= {w_rx, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_ustate <= U_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        U_STOP: begin
          if (r_clk_cnt == FULL_M1) begin
            r_clk_cnt <= '0;
            if (w_rx) r_byte_valid <= 1'b1;
            else      r_frame_err  <= 1'b1;
            r_ustate <= U_IDLE;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_ustate <= U_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fstate    <= F_SYNC;
      r_len       <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_prog_we   <= 1'b0;
      r_prog_addr <= '0;
      r_prog_data <= '0;
      r_cpu_run   <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_prog_we <= 1'b0;
      if (r_frame_err && (r_fstate != F_DONE)) begin
        r_err    <= 1'b1;
        r_busy   <= 1'b0;
        r_fstate <= F_SYNC;
      end else if (r_byte_valid) begin
        case (r_fstate)
          F_SYNC: begin
            if (r_shift == SYNC_BYTE) begin
              r_err    <= 1'b0;
              r_busy   <= 1'b1;
              r_fstate <= F_LEN;
            end
          end
          F_LEN: begin
            if ((r_shift == 8'd0) || (r_shift > MAX_LEN)) begin
              r_err    <= 1'b1;
              r_busy   <= 1'b0;
              r_fstate <= F_SYNC;
            end else begin
              r_len    <= r_shift;
              r_sum    <= r_shift;
              r_cnt    <= '0;
              r_fstate <= F_DATA;
            end
          end
          F_DATA: begin
            // r_cnt stays below LEN, which is bounded by MEM_DEPTH, so the address is always legal.
            r_prog_we   <= 1'b1;
            r_prog_addr <= r_cnt;
            r_prog_data <= r_shift;
            r_sum       <= r_sum + r_shift;
            r_cnt       <= r_cnt + 5'd1;
            if (({3'b000, r_cnt} + 8'd1) == r_len) r_fstate <= F_CHK;
          end
          F_CHK: begin
            r_busy <= 1'b0;
            if (r_shift == r_sum) begin
              r_cpu_run <= 1'b1;
              r_fstate  <= F_DONE;
            end else begin
              r_err    <= 1'b1;
              r_fstate <= F_SYNC;
            end
          end
          F_DONE: ;
          default: begin
            r_busy   <= 1'b0;
            r_fstate <= F_SYNC;
          end
        endcase
      end
    end
  end

  assign prog_we   = r_prog_we;
  assign prog_addr = r_prog_addr;
  assign prog_data = r_prog_data;
  assign cpu_run   = r_cpu_run;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, giving clk cycles per UART bit period (>= 4).
REQ-002 SHALL have parameter MEM_DEPTH, default 19, giving the maximum loadable program bytes (addresses 0..MEM_DEPTH-1).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rx  input  1  asynchronous UART serial input, idle high, 8N1, LSB first.
REQ-006 SHALL have port prog_we  output  1  instruction-memory write strobe, one clk per byte.
REQ-007 SHALL have port prog_addr  output  5  instruction-memory write address.
REQ-008 SHALL have port prog_data  output  8  instruction-memory write data.
REQ-009 SHALL have port cpu_run  output  1  program loaded and checksum-verified; CPU released.
REQ-010 SHALL have port busy  output  1  frame reception in progress.
REQ-011 SHALL have port err  output  1  sticky frame error flag.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-013 UART RX FSM SHALL use states IDLE, START, DATA, STOP; IDLE->START on synchronized rx low.
REQ-014 START SHALL re-sample rx at CLKS_PER_BIT/2 cycles; low -> DATA, high -> IDLE (glitch rejected, no byte, no error).
REQ-015 DATA SHALL sample 8 bits at CLKS_PER_BIT intervals from mid-start, shifting LSB first.
REQ-016 STOP SHALL sample rx one period after bit 7; high -> one-cycle byte_valid pulse next cycle; low -> framing error, no byte_valid.
REQ-017 Frame format SHALL be: 0xA5 sync, LEN, LEN data bytes, CHK, where CHK = (LEN + sum of data bytes) mod 256.
REQ-018 Frame FSM SHALL use states SYNC, LEN, DATA, CHK, DONE.
REQ-019 SYNC: bytes other than 0xA5 SHALL be discarded silently; 0xA5 -> LEN, clears err.
REQ-020 LEN: 1..MEM_DEPTH -> store count, seed running sum with LEN, prog_addr counter := 0, -> DATA; 0 or > MEM_DEPTH -> err := 1, -> SYNC.
REQ-021 DATA: each byte SHALL drive prog_data := byte, prog_addr := counter, prog_we := 1 for exactly one clk, registered the cycle after byte_valid; counter increments; after LEN bytes -> CHK.
REQ-022 Running sum SHALL be 8 bits, wrapping modulo 256.
REQ-023 CHK: match -> DONE; mismatch -> err := 1, -> SYNC; bytes already written are not undone.
REQ-024 DONE SHALL be terminal until reset: cpu_run = 1, all further rx bytes ignored, prog_we held 0.
REQ-025 UART framing error in any frame state other than DONE SHALL set err := 1 and return frame FSM to SYNC.
REQ-026 busy SHALL be 1 exactly when frame FSM is in LEN, DATA or CHK.
REQ-027 prog_we SHALL never assert while cpu_run = 1; prog_addr SHALL never exceed MEM_DEPTH-1.
REQ-028 prog_addr and prog_data SHALL hold their last values when prog_we = 0.

Reset
REQ-029 While rst_n = 0 at a clk edge: both FSMs -> IDLE/SYNC; prog_we, prog_addr, prog_data, cpu_run, busy, err, counters, and sum := 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame; the next frame SHALL require a fresh 0xA5.

Verification (CLKS_PER_BIT = 8, MEM_DEPTH = 19)
REQ-031 Reset, rx idle high -> all outputs 0 and remain 0 for 100 clk.
REQ-032 Frame A5 03 01 2A 0A 38 -> writes (0,0x01), (1,0x2A), (2,0x0A), each prog_we one clk; then cpu_run = 1, err = 0, busy = 0.
REQ-033 Frame A5 03 01 2A 0A 39 -> same three writes, cpu_run = 0, err = 1; then A5 01 07 08 -> err cleared on A5, write (0,0x07), cpu_run = 1.
REQ-034 A5 14 (LEN = 20) -> err = 1, no prog_we; A5 00 -> err = 1, no prog_we.
REQ-035 Stop bit driven low on second data byte -> err = 1, one write only, FSM back to SYNC; rx low for 2 clk then high -> no byte, no err.
REQ-036 rst_n pulsed low after 2 of 3 data bytes -> all outputs 0; a following valid frame loads from address 0 and sets cpu_run = 1.
